// File: rtl/fixed_accum_pkg.sv
// ---------------------------------------------------------------------------
// fixed_accum_pkg
//   Shared helpers for the fixed-point vector accumulator.
//   - accum_width(): lane width needed to sum `depth` signed values of
//     `in_width` bits without overflow.
//   - sign_extend(): widens a two's-complement value of run-time width
//     `width` to SEXT_W bits. Callers truncate the result to their own
//     lane width with a cast.
// ---------------------------------------------------------------------------
package fixed_accum_pkg;

  localparam int SEXT_W = 64;

  function automatic int accum_width(input int in_width, input int depth);
    return in_width + $clog2(depth);
  endfunction

  function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] value,
                                                    input int                width);
    logic [SEXT_W-1:0] result;
    result = value;
    for (int i = 0; i < SEXT_W; i++) begin
      if (i >= width) begin
        result[i] = value[width-1];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fixed_accumulator_lane.sv
// ---------------------------------------------------------------------------
// fixed_accumulator_lane
//   One lane of the vector accumulator: a single signed accumulator register.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (clears acc)
//     load_i     overwrite acc with the sign-extended input (first beat)
//     add_i      add the sign-extended input to acc (subsequent beats)
//     data_i     signed input lane, IN_WIDTH bits
//     acc_o      accumulated value, OUT_WIDTH bits
//   With neither load_i nor add_i asserted the register holds.
// ---------------------------------------------------------------------------
module fixed_accumulator_lane
  import fixed_accum_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 add_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] acc_o
);

  logic [OUT_WIDTH-1:0] data_ext;
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] acc_d;

  assign data_ext = OUT_WIDTH'(sign_extend(SEXT_W'(data_i), IN_WIDTH));

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = data_ext;
    end else if (add_i) begin
      // OUT_WIDTH is sized for the full group sum, so this never wraps.
      acc_d = acc_q + data_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fixed_vector_accumulator.sv
// ---------------------------------------------------------------------------
// fixed_vector_accumulator
//   Streaming per-lane signed fixed-point accumulator. Sums IN_DEPTH accepted
//   beats of an IN_SIZE-lane vector lane by lane and presents one
//   full-precision vector (OUT_WIDTH bits per lane, same fractional point)
//   per group. Intended to feed a rounding stage that narrows the sums.
//
//   Ports:
//     clk             clock
//     rst             synchronous active-high reset, priority over all else
//     clear           (only with FIXED_VECTOR_ACCUMULATOR_CLEAR_EN) abandons
//                     the current group and any pending output
//     data_in         IN_SIZE signed lanes of IN_WIDTH bits
//     data_in_valid   input beat valid
//     data_in_ready   input beat accepted when valid && ready
//     data_out        IN_SIZE signed lane sums of OUT_WIDTH bits
//     data_out_valid  output vector valid
//     data_out_ready  downstream accepts the output vector
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   data_out_valid is registered and, once high, stays high with data_out
//   stable until data_out_ready. data_in_ready = !data_out_valid ||
//   data_out_ready (and !clear when enabled), so a new group can start in
//   the same cycle the previous result drains.
//
//   Optional feature macro: FIXED_VECTOR_ACCUMULATOR_CLEAR_EN adds `clear`.
// ---------------------------------------------------------------------------
module fixed_vector_accumulator
  import fixed_accum_pkg::*;
#(
  parameter  int IN_SIZE       = 4,
  parameter  int IN_WIDTH      = 8,
  parameter  int IN_FRAC_WIDTH = 3,
  parameter  int IN_DEPTH      = 4,
  localparam int OUT_WIDTH     = accum_width(IN_WIDTH, IN_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FIXED_VECTOR_ACCUMULATOR_CLEAR_EN
  input  logic                 clear,
`endif
  input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE-1:0],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [OUT_WIDTH-1:0] data_out [IN_SIZE-1:0],
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  // A one-bit counter is kept even for IN_DEPTH == 1; it simply stays 0.
  localparam int                CNT_W     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(IN_DEPTH - 1);

  // The fractional width only travels alongside the data to the rounding
  // stage; here it is just sanity-checked at elaboration.
  if (IN_DEPTH < 1 || IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH > IN_WIDTH) begin : g_param_check
    $error("fixed_vector_accumulator: illegal IN_DEPTH or IN_FRAC_WIDTH");
  end

  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             accept;
  logic             last_beat;
  logic             out_hs;
  logic             lane_load;
  logic             lane_add;

  always_comb begin
    data_in_ready = !out_valid_q || data_out_ready;
`ifdef FIXED_VECTOR_ACCUMULATOR_CLEAR_EN
    if (clear) begin
      data_in_ready = 1'b0;
    end
`endif
  end

  assign accept    = data_in_valid && data_in_ready;
  assign last_beat = accept && (beat_cnt_q == LAST_BEAT);
  assign out_hs    = out_valid_q && data_out_ready;
  assign lane_load = accept && (beat_cnt_q == '0);
  assign lane_add  = accept && (beat_cnt_q != '0);

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
    end
    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    // A group completing in the drain cycle (IN_DEPTH == 1) keeps valid up.
    if (last_beat) begin
      out_valid_d = 1'b1;
    end
`ifdef FIXED_VECTOR_ACCUMULATOR_CLEAR_EN
    // Accept is blocked while clear is high, so nothing above conflicts.
    if (clear) begin
      beat_cnt_d  = '0;
      out_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar g = 0; g < IN_SIZE; g++) begin : g_lane
    fixed_accumulator_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (lane_load),
      .add_i  (lane_add),
      .data_i (data_in[g]),
      .acc_o  (data_out[g])
    );
  end

  assign data_out_valid = out_valid_q;

endmodule

// File: tb/tb_fixed_vector_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fixed_vector_accumulator
//   Self-checking bench for fixed_vector_accumulator with IN_SIZE=2,
//   IN_WIDTH=8, IN_DEPTH=4 (OUT_WIDTH=10). A reference model collects the
//   accepted beats of each group as plain integers, sums them when the group
//   is complete and queues the expected output vector. Handshake readiness
//   and output valid are predicted from the model's own pending-result state.
//   Build with +define+FIXED_VECTOR_ACCUMULATOR_CLEAR_EN to cover `clear`.
// ---------------------------------------------------------------------------
module tb_fixed_vector_accumulator;

  localparam int IN_SIZE       = 2;
  localparam int IN_WIDTH      = 8;
  localparam int IN_FRAC_WIDTH = 3;
  localparam int IN_DEPTH      = 4;
  localparam int OUT_W         = 10;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef FIXED_VECTOR_ACCUMULATOR_CLEAR_EN
  logic clear = 1'b0;
`endif
  always #5 clk = ~clk;

  logic [IN_WIDTH-1:0] data_in [IN_SIZE-1:0];
  logic                data_in_valid;
  logic                data_in_ready;
  logic [OUT_W-1:0]    data_out [IN_SIZE-1:0];
  logic                data_out_valid;
  logic                data_out_ready;

  fixed_vector_accumulator #(
    .IN_SIZE       (IN_SIZE),
    .IN_WIDTH      (IN_WIDTH),
    .IN_FRAC_WIDTH (IN_FRAC_WIDTH),
    .IN_DEPTH      (IN_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef FIXED_VECTOR_ACCUMULATOR_CLEAR_EN
    .clear          (clear),
`endif
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit clear_now();
`ifdef FIXED_VECTOR_ACCUMULATOR_CLEAR_EN
    return clear;
`else
    return 1'b0;
`endif
  endfunction

  // -------------------------------------------------------------------------
  // Reference model + scoreboard
  //   At each falling edge the DUT state reflects all inputs up to the last
  //   rising edge; the inputs now visible are what the next edge samples.
  // -------------------------------------------------------------------------
  logic [IN_SIZE*OUT_W-1:0] exp_q[$];
  int beats0[$];
  int beats1[$];
  bit mdl_valid = 1'b0;
  bit zero_chk  = 1'b0;

  always @(negedge clk) begin
    bit clr;
    bit exp_rdy;
    bit hs;
    bit acc;
    int s0;
    int s1;
    clr     = clear_now();
    exp_rdy = (!mdl_valid || data_out_ready) && !clr;
    check("in_ready", data_in_ready, exp_rdy);
    check("out_valid", data_out_valid, mdl_valid);
    if (zero_chk) begin
      for (int i = 0; i < IN_SIZE; i++) check("reset_data", data_out[i], 0);
    end
    if (mdl_valid) begin
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        for (int i = 0; i < IN_SIZE; i++)
          check("out_data", data_out[i], exp_q[0][i*OUT_W +: OUT_W]);
      end
    end
    zero_chk = 1'b0;
    if (rst) begin
      mdl_valid = 1'b0;
      beats0.delete();
      beats1.delete();
      exp_q.delete();
      zero_chk = 1'b1;
    end else begin
      hs  = mdl_valid && data_out_ready;
      acc = data_in_valid && exp_rdy;
      if (hs) begin
        void'(exp_q.pop_front());
        mdl_valid = 1'b0;
      end
      if (clr) begin
        beats0.delete();
        beats1.delete();
        exp_q.delete();
        mdl_valid = 1'b0;
      end
      if (acc) begin
        beats0.push_back(int'($signed(data_in[0])));
        beats1.push_back(int'($signed(data_in[1])));
        if (beats0.size() == IN_DEPTH) begin
          s0 = 0;
          s1 = 0;
          foreach (beats0[k]) s0 += beats0[k];
          foreach (beats1[k]) s1 += beats1[k];
          exp_q.push_back({OUT_W'(s1), OUT_W'(s0)});
          mdl_valid = 1'b1;
          beats0.delete();
          beats1.delete();
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  bit rand_rdy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) data_out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input int a, input int b);
    bit got;
    got = 1'b0;
    data_in[0]    = IN_WIDTH'(a);
    data_in[1]    = IN_WIDTH'(b);
    data_in_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = data_in_ready;
      @(posedge clk);
      #1;
    end
    data_in_valid = 1'b0;
    check("send_accept", got, 1);
  endtask

  task automatic idle(input int n);
    data_in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    data_in[0]     = '0;
    data_in[1]     = '0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Extreme values: {508, -512}
    repeat (4) send(127, -128);
    idle(3);

    // Mixed signs, then a zero group to show the old sum is discarded
    send(5, 1);
    send(-3, 1);
    send(10, 1);
    send(-20, 1);
    repeat (4) send(0, 0);
    idle(2);

    // Backpressure: output held for 5 cycles with a beat waiting
    repeat (4) send(3, -3);
    data_out_ready = 1'b0;
    data_in[0]     = IN_WIDTH'(9);
    data_in[1]     = IN_WIDTH'(9);
    data_in_valid  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    data_out_ready = 1'b1;
    send(9, 9);
    repeat (3) send(1, 1);
    idle(3);

    // Gapped input: valid pattern 1,0,0,1,0,1,1
    send(1, -1);
    idle(2);
    send(2, -2);
    idle(1);
    send(3, -3);
    send(4, -4);
    idle(3);

    // Reset in the middle of a group
    send(50, 50);
    send(50, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) send(1, 1);
    idle(3);

`ifdef FIXED_VECTOR_ACCUMULATOR_CLEAR_EN
    // Clear abandons a partial group; the offered beat is not taken
    repeat (3) send(7, 7);
    clear         = 1'b1;
    data_in[0]    = IN_WIDTH'(5);
    data_in[1]    = IN_WIDTH'(5);
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear         = 1'b0;
    data_in_valid = 1'b0;
    repeat (4) send(2, 2);
    idle(3);
`endif

    // Random values, random gaps, random downstream readiness
    rand_rdy = 1'b1;
    repeat (80) begin
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    idle(5);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected end before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/fixed_vector_accumulator.md
Name: fixed_vector_accumulator

Overview:
- Streaming per-lane signed fixed-point accumulator with valid/ready handshakes.
- Sums IN_DEPTH consecutive input beats of an IN_SIZE-lane vector, lane by lane, and emits one full-precision vector per IN_DEPTH beats.
- Sits directly upstream of fixed_rounding. Its output feeds that stage, which narrows the grown-width sums back to the datapath format.
- Fractional point is unchanged. Output fractional width = IN_FRAC_WIDTH.

Parameters:
- IN_SIZE, 4, number of lanes per beat.
- IN_WIDTH, 8, signed two's-complement input lane width.
- IN_FRAC_WIDTH, 3, input fractional bits. Passed through for downstream rounding; not used arithmetically.
- IN_DEPTH, 4, beats summed per output, ≥1.
- OUT_WIDTH, IN_WIDTH+$clog2(IN_DEPTH), output lane width. Derived localparam; must not be overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  [IN_WIDTH-1:0] x [IN_SIZE-1:0]  signed input lanes.
- data_in_valid  input  1  input beat valid.
- data_in_ready  output  1  input beat accepted when valid&&ready.
- data_out  output  [OUT_WIDTH-1:0] x [IN_SIZE-1:0]  signed lane sums.
- data_out_valid  output  1  output vector valid.
- data_out_ready  input  1  downstream accepts.
- Interface constraint: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: beat_cnt=0, acc lanes=0, data_out_valid=0, data_out=0. data_in_ready is 1 on the first cycle after reset.
- data_in_ready = !data_out_valid || data_out_ready. This is combinational, with no bubble when the output is drained the same cycle.
- On accept with beat_cnt==0: acc[i] <= sign_extend(data_in[i]). This discards the previous sum.
- On accept with beat_cnt>0: acc[i] <= acc[i] + sign_extend(data_in[i]).
- beat_cnt increments on accept. It wraps to 0 on the accept where beat_cnt==IN_DEPTH-1. On that same accept, data_out_valid <= 1.
- data_out is driven directly from acc.
- Latency: data_out_valid rises 1 cycle after the last beat is accepted.
- data_out_valid clears on a data_out_ready handshake, unless the same cycle also accepts a final beat (possible only when IN_DEPTH==1). In that case it stays 1.
- Backpressure: while data_out_valid && !data_out_ready, data_in_ready=0 and acc/data_out are held stable.
- The first beat of the next group may be accepted in the same cycle the output handshakes. acc is overwritten only on the following edge, so the handshaked value is correct.
- IN_DEPTH==1: a registered pass-through with sign extension. Throughput is 1 beat/cycle when data_out_ready is held at 1.
- Width: OUT_WIDTH guarantees no overflow. There is no saturation and no wrap logic.
- Idle gaps (valid=0) between beats of a group are allowed. The partial sum is retained.
- rst asserted mid-group discards the partial sum and beat_cnt. rst has priority over every handshake.

Optional Feature:
- Macro FIXED_VECTOR_ACCUMULATOR_CLEAR_EN.
- When defined:
  - Adds input port `clear` (1 bit) after rst.
  - clear=1 synchronously sets beat_cnt=0 and data_out_valid=0, and blocks accept that cycle (data_in_ready=0).
  - acc is left unchanged. It is overwritten by the next first beat.
  - rst has priority over clear.
- When undefined: no port and no logic; behaviour is exactly as above.

Decomposition:
- Package fixed_accum_pkg holds:
  - function accum_width(in_width, depth) returning in_width+$clog2(depth).
  - A sign-extension function.
- Sub-module fixed_accumulator_lane: one lane's acc register with load/add/hold controls.
- The top module owns beat_cnt, the handshake, and the optional clear, and instantiates IN_SIZE lanes via a generate loop.

Test Plan (IN_SIZE=2, IN_WIDTH=8, IN_DEPTH=4, OUT_WIDTH=10, data_out_ready=1 unless stated):
- Saturating extremes: lane0=127 ×4, lane1=-128 ×4 → data_out={508,-512} (lane0=0x1FC, lane1=0x200), valid for 1 cycle, 1 cycle after the 4th accept.
- Mixed signs: lane0 beats 5,-3,10,-20; lane1 1,1,1,1 → {-8,4}. A second group of zeros then yields {0,0}, proving a fresh load.
- Backpressure: ready=0 for 5 cycles after valid → data_out stable, data_in_ready=0 for 5 cycles; the release cycle accepts the next first beat with no lost beats.
- Gapped input: valid toggling 1,0,0,1,0,1,1 with values 1,2,3,4 → single output 10 after the 4th accept.
- Reset mid-group: 2 beats of 50, then rst for 1 cycle, then 4 beats of 1 → output 4; data_out_valid=0 during and after rst.
- CLEAR_EN build: 3 beats of 7, clear pulse, then 4 beats of 2 → output 8; data_in_ready=0 in the clear cycle.
